// File: rtl/rps_pkg.sv
// Shared types and the winner rule for the rock-paper-scissors round controller.
package rps_pkg;

  typedef enum logic [1:0] {
    MOVE_NONE = 2'd0,
    ROCK      = 2'd1,
    PAPER     = 2'd2,
    SCISSORS  = 2'd3
  } move_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    P1_WIN   = 2'd1,
    P2_WIN   = 2'd2,
    TIE      = 2'd3
  } result_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SHOW    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // All-ones history makes buttons held through reset look already pressed.
  localparam logic [2:0] BTN_HIST_RST = 3'b111;

  // A lone latched move beats an absent one, which is how a forfeit is scored.
  function automatic result_t rps_judge(input move_t a, input move_t b);
    result_t r;
    if ((a == MOVE_NONE) && (b == MOVE_NONE)) begin
      r = RES_NONE;
    end else if (b == MOVE_NONE) begin
      r = P1_WIN;
    end else if (a == MOVE_NONE) begin
      r = P2_WIN;
    end else if (a == b) begin
      r = TIE;
    end else if (((a == ROCK) && (b == SCISSORS)) ||
                 ((a == PAPER) && (b == ROCK)) ||
                 ((a == SCISSORS) && (b == PAPER))) begin
      r = P1_WIN;
    end else begin
      r = P2_WIN;
    end
    return r;
  endfunction

endpackage

// File: rtl/rps_press_detect.sv
// Rising-edge detector for one player's three debounced buttons; only a
// single-button rise counts as a press.
module rps_press_detect
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  output logic       valid,
  output move_t      move
);

  logic [2:0] prev_r;
  logic [2:0] rise_s;

  assign rise_s = btn & ~prev_r;

  // Edge history tracks the button levels every cycle regardless of round state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r <= BTN_HIST_RST;
    end else begin
      prev_r <= btn;
    end
  end

  // Decode a one-hot rise into a move; simultaneous rises are dropped.
  always_comb begin
    valid = 1'b0;
    move  = MOVE_NONE;
    case (rise_s)
      3'b001: begin
        valid = 1'b1;
        move  = ROCK;
      end
      3'b010: begin
        valid = 1'b1;
        move  = PAPER;
      end
      3'b100: begin
        valid = 1'b1;
        move  = SCISSORS;
      end
      default: begin
        valid = 1'b0;
        move  = MOVE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round controller: latch moves, judge, show, wait for release.
// Optional forfeit timeout in COLLECT is built when RPS_TIMEOUT_EN is defined.
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned RESULT_CYCLES  = 25000000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         p1_btn,
  input  logic [2:0]         p2_btn,
  input  logic               score_clr,
  output logic [1:0]         p1_move,
  output logic [1:0]         p2_move,
  output logic [1:0]         result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score
);

  localparam int unsigned        SHOW_W    = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [SHOW_W-1:0]  SHOW_LAST = SHOW_W'(RESULT_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state_r, state_next_s;
  move_t              p1_move_r, p2_move_r, p1_move_nxt_s, p2_move_nxt_s;
  result_t            result_r, result_nxt_s, judge_s;
  logic               result_valid_r, result_valid_nxt_s;
  logic [SCORE_W-1:0] p1_score_r, p2_score_r, p1_score_nxt_s, p2_score_nxt_s;
  logic [SHOW_W-1:0]  show_cnt_r;
  logic               p1_valid_s, p2_valid_s;
  move_t              p1_press_s, p2_press_s;
  logic               both_latched_s, btns_idle_s, timeout_s;
  logic               p1_inc_s, p2_inc_s;

  rps_press_detect u_p1_press (
    .clk   (clk),
    .reset (reset),
    .btn   (p1_btn),
    .valid (p1_valid_s),
    .move  (p1_press_s)
  );

  rps_press_detect u_p2_press (
    .clk   (clk),
    .reset (reset),
    .btn   (p2_btn),
    .valid (p2_valid_s),
    .move  (p2_press_s)
  );

  assign both_latched_s = (p1_move_r != MOVE_NONE) && (p2_move_r != MOVE_NONE);
  assign btns_idle_s    = ({p1_btn, p2_btn} == 6'b000000);
  assign judge_s        = rps_judge(p1_move_r, p2_move_r);

`ifdef RPS_TIMEOUT_EN
  localparam int unsigned    TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_r;
  logic            one_sided_s, other_press_s;

  assign one_sided_s   = (p1_move_r != MOVE_NONE) ^ (p2_move_r != MOVE_NONE);
  assign other_press_s = (p1_move_r == MOVE_NONE) ? p1_valid_s : p2_valid_s;
  // A late press by the waiting player on the last cycle still wins the race.
  assign timeout_s     = (state_r == ST_COLLECT) && one_sided_s &&
                         (to_cnt_r == TO_LAST) && !other_press_s;

  // Forfeit window counts only while exactly one player has latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if ((state_r == ST_COLLECT) && one_sided_s) begin
      to_cnt_r <= to_cnt_r + TO_W'(1'b1);
    end else begin
      to_cnt_r <= {TO_W{1'b0}};
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_COLLECT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_COLLECT: begin
        if (both_latched_s || timeout_s) begin
          state_next_s = ST_SHOW;
        end else begin
          state_next_s = ST_COLLECT;
        end
      end
      ST_SHOW: begin
        if (show_cnt_r == SHOW_LAST) begin
          state_next_s = ST_RELEASE;
        end else begin
          state_next_s = ST_SHOW;
        end
      end
      ST_RELEASE: begin
        if (btns_idle_s) begin
          state_next_s = ST_COLLECT;
        end else begin
          state_next_s = ST_RELEASE;
        end
      end
      default: state_next_s = ST_COLLECT;
    endcase
  end

  // Next values of the registered outputs, including scoring on SHOW entry.
  always_comb begin
    p1_move_nxt_s      = p1_move_r;
    p2_move_nxt_s      = p2_move_r;
    result_nxt_s       = result_r;
    result_valid_nxt_s = 1'b0;
    p1_inc_s           = 1'b0;
    p2_inc_s           = 1'b0;
    case (state_r)
      ST_COLLECT: begin
        if (state_next_s == ST_SHOW) begin
          result_nxt_s       = judge_s;
          result_valid_nxt_s = 1'b1;
          p1_inc_s           = (judge_s == P1_WIN);
          p2_inc_s           = (judge_s == P2_WIN);
        end else begin
          if ((p1_move_r == MOVE_NONE) && p1_valid_s) begin
            p1_move_nxt_s = p1_press_s;
          end else begin
            p1_move_nxt_s = p1_move_r;
          end
          if ((p2_move_r == MOVE_NONE) && p2_valid_s) begin
            p2_move_nxt_s = p2_press_s;
          end else begin
            p2_move_nxt_s = p2_move_r;
          end
        end
      end
      ST_SHOW: begin
        result_valid_nxt_s = (state_next_s == ST_SHOW);
      end
      ST_RELEASE: begin
        if (state_next_s == ST_COLLECT) begin
          p1_move_nxt_s = MOVE_NONE;
          p2_move_nxt_s = MOVE_NONE;
          result_nxt_s  = RES_NONE;
        end else begin
          result_nxt_s  = result_r;
        end
      end
      default: begin
        p1_move_nxt_s = MOVE_NONE;
        p2_move_nxt_s = MOVE_NONE;
        result_nxt_s  = RES_NONE;
      end
    endcase

    // Clear beats a same-cycle win; otherwise scores saturate.
    if (score_clr) begin
      p1_score_nxt_s = {SCORE_W{1'b0}};
      p2_score_nxt_s = {SCORE_W{1'b0}};
    end else begin
      if (p1_inc_s && (p1_score_r != SCORE_MAX)) begin
        p1_score_nxt_s = p1_score_r + SCORE_W'(1'b1);
      end else begin
        p1_score_nxt_s = p1_score_r;
      end
      if (p2_inc_s && (p2_score_r != SCORE_MAX)) begin
        p2_score_nxt_s = p2_score_r + SCORE_W'(1'b1);
      end else begin
        p2_score_nxt_s = p2_score_r;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_move_r      <= MOVE_NONE;
      p2_move_r      <= MOVE_NONE;
      result_r       <= RES_NONE;
      result_valid_r <= 1'b0;
      p1_score_r     <= {SCORE_W{1'b0}};
      p2_score_r     <= {SCORE_W{1'b0}};
    end else begin
      p1_move_r      <= p1_move_nxt_s;
      p2_move_r      <= p2_move_nxt_s;
      result_r       <= result_nxt_s;
      result_valid_r <= result_valid_nxt_s;
      p1_score_r     <= p1_score_nxt_s;
      p2_score_r     <= p2_score_nxt_s;
    end
  end

  // Display-window counter runs from zero on the SHOW entry cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      show_cnt_r <= {SHOW_W{1'b0}};
    end else if (state_r == ST_SHOW) begin
      show_cnt_r <= show_cnt_r + SHOW_W'(1'b1);
    end else begin
      show_cnt_r <= {SHOW_W{1'b0}};
    end
  end

  assign p1_move      = p1_move_r;
  assign p2_move      = p2_move_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign p1_score     = p1_score_r;
  assign p2_score     = p2_score_r;

endmodule

// File: doc/rps_round_ctrl.md
Name: rps_round_ctrl

Overview:
- Round controller for the rock-paper-scissors game.
- Sits directly downstream of the per-button debounce shift registers.
- Consumes six debounced button levels (3 per player) and turns rising edges into latched moves.
- Decides the winner, holds the result for a display window and keeps saturating per-player scores.

Parameters:
- SCORE_W, 4, width of each score counter.
- RESULT_CYCLES, 25000000, cycles the result is held in SHOW (>=1).
- TIMEOUT_CYCLES, 250000000, forfeit window; used only with RPS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- p1_btn  in  3  player 1 debounced levels {scissors,paper,rock}.
- p2_btn  in  3  player 2 debounced levels, same order.
- score_clr  in  1  synchronous clear of both scores.
- p1_move  out  2  latched move: 0 NONE, 1 ROCK, 2 PAPER, 3 SCISSORS.
- p2_move  out  2  same encoding.
- result  out  2  0 NONE, 1 P1_WIN, 2 P2_WIN, 3 TIE.
- result_valid  out  1  high exactly while in SHOW.
- p1_score  out  SCORE_W  player 1 wins.
- p2_score  out  SCORE_W  player 2 wins.

Behaviour:
- Reset values:
  - state=COLLECT, all outputs 0.
  - Edge-history registers = 3'b111, so buttons held through reset never count as presses.
- Edge detect, per player:
  - press = btn & ~prev; prev <= btn every cycle in every state.
  - A press is valid only if exactly one bit rises (one-hot).
  - Multi-bit rises in one cycle are ignored.
- COLLECT:
  - Each player's first valid press latches the move; p*_move is updated the next cycle.
  - Further presses by a player who has already latched are ignored.
  - Both players may latch in the same cycle.
  - When both moves are non-NONE, go to SHOW next cycle.
  - In the SHOW entry cycle: result registered, result_valid=1, winner's score incremented.
- Winner rules:
  - ROCK beats SCISSORS, PAPER beats ROCK, SCISSORS beats PAPER.
  - Equal moves give TIE; no score change on TIE.
- Scores:
  - Saturate at 2^SCORE_W-1.
  - score_clr zeros both scores in any state and takes priority over a same-cycle increment.
- SHOW:
  - Lasts exactly RESULT_CYCLES cycles, counted by an internal counter wide enough for the parameter.
  - Then go to RELEASE.
- RELEASE:
  - result_valid=0; result and moves are still held.
  - Stay while any p1_btn/p2_btn bit is 1.
  - When all six bits are 0: clear moves and result to NONE and enter COLLECT next cycle.
  - Minimum residency is 1 cycle.
- Presses during SHOW/RELEASE are discarded; they are not queued.
- Reset asserted mid-round returns to reset values immediately (asynchronous). Scores are lost.

Optional Feature:
- Macro: RPS_TIMEOUT_EN.
- Defined:
  - In COLLECT, a counter starts in the cycle after exactly one player has latched.
  - If TIMEOUT_CYCLES elapse without the other player latching, enter SHOW.
  - The latched player wins and scores; the other move stays NONE.
  - The counter clears on leaving COLLECT.
- Undefined:
  - COLLECT waits indefinitely.
  - No timeout counter is synthesized; TIMEOUT_CYCLES is unused.

Decomposition:
- Package rps_pkg:
  - move_t enum (NONE/ROCK/PAPER/SCISSORS).
  - result_t enum (NONE/P1_WIN/P2_WIN/TIE).
  - state_t enum (COLLECT/SHOW/RELEASE).
  - Function rps_judge(move_t a, move_t b) returning result_t.
- Sub-module rps_press_detect:
  - Holds the 3-bit edge history (reset 3'b111).
  - Produces a valid strobe plus move_t.
  - Instantiated once per player.

Test Plan (RESULT_CYCLES=4, TIMEOUT_CYCLES=8, SCORE_W=2):
- Basic win: p1 rock rises at cycle 10, p2 scissors at 12, both released at 20 -> p1_move=1 from 11; p2_move=3 from 13; result=P1_WIN with result_valid high cycles 14-17; p1_score=1; COLLECT with moves NONE at 21.
- Simultaneous latch and tie: both press paper in the same cycle -> SHOW next cycle, result=TIE, scores unchanged.
- Held-through-reset and multi-bit press: p1_btn=3'b001 held across reset deassert -> no latch. p1_btn 000->011 -> ignored. Then 000->010 -> p1_move=PAPER.
- Release gating and saturation: four consecutive p2 wins with p2 holding a button after the third -> RELEASE persists until release; p2_score sticks at 3. Pulse score_clr during the final SHOW entry cycle -> both scores 0.
- Mid-round reset and ignored presses: presses during SHOW are not latched into the next round; reset pulled low during SHOW -> all outputs 0 the same cycle, COLLECT afterwards.
- RPS_TIMEOUT_EN defined: p1 latches rock, p2 idle -> SHOW after 8 cycles with P1_WIN, p2_move=NONE. Macro undefined, same stimulus -> remains in COLLECT for 100 cycles.
